// File: rtl/iob_cache_line_refill_pkg.sv
// Shared definitions for the cache line refill block.
// Contents:
//   refill_state_t : 2-bit FSM state encoding (IDLE, SELECT, FILL, COMMIT)
package iob_cache_line_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } refill_state_t;

endpackage

// File: rtl/iob_cache_prio_enc.sv
// Lowest-set-bit priority encoder used to find the first invalid way.
// Ports:
//   in_i    : N-bit request vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : high when at least one bit of in_i is set
module iob_cache_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_cache_line_refill.sv
// Cache miss handler: chooses a victim way, fetches the full line from the
// back-end one word at a time, writes it into the data memory, then commits
// tag/valid and tells the replacement policy the refilled way is now MRU.
// Ports:
//   clk_i, arst_n_i, cke_i           : clock, async active-low reset, clock enable
//   miss_valid_i/_ready_o, line, tag : miss request handshake and address
//   valid_bits_i, rep_sel_i/_bin_i   : valid bits and policy victim of rep_line_o
//   rep_line_o, rep_we_o, rep_hit_o  : line index and MRU update to the policy
//   be_req_o, be_addr_o, be_ack_i,
//   be_rdata_i                       : back-end word read interface
//   data_we_o, data_way_o,
//   data_word_o, data_wdata_o        : data memory write port
//   tag_we_o, tag_o                  : tag/valid memory write port
//   done_o                           : one-cycle refill-complete pulse
module iob_cache_line_refill
  import iob_cache_line_refill_pkg::*;
#(
  parameter int N_WAYS        = 8,
  parameter int NWAYS_W       = $clog2(N_WAYS),
  parameter int NLINES_W      = 7,
  parameter int TAG_W         = 20,
  parameter int WORD_OFFSET_W = 3,
  parameter int DATA_W        = 32
) (
  input  logic                                    clk_i,
  input  logic                                    arst_n_i,
  input  logic                                    cke_i,
  input  logic                                    miss_valid_i,
  output logic                                    miss_ready_o,
  input  logic [NLINES_W-1:0]                     miss_line_i,
  input  logic [TAG_W-1:0]                        miss_tag_i,
  input  logic [N_WAYS-1:0]                       valid_bits_i,
  input  logic [N_WAYS-1:0]                       rep_sel_i,
  input  logic [NWAYS_W-1:0]                      rep_sel_bin_i,
  output logic [NLINES_W-1:0]                     rep_line_o,
  output logic                                    rep_we_o,
  output logic [N_WAYS-1:0]                       rep_hit_o,
  output logic                                    be_req_o,
  output logic [TAG_W+NLINES_W+WORD_OFFSET_W-1:0] be_addr_o,
  input  logic                                    be_ack_i,
  input  logic [DATA_W-1:0]                       be_rdata_i,
  output logic                                    data_we_o,
  output logic [NWAYS_W-1:0]                      data_way_o,
  output logic [WORD_OFFSET_W-1:0]                data_word_o,
  output logic [DATA_W-1:0]                       data_wdata_o,
  output logic                                    tag_we_o,
  output logic [TAG_W-1:0]                        tag_o,
  output logic                                    done_o
);

  refill_state_t              state_q, state_d;
  logic [WORD_OFFSET_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [NLINES_W-1:0]        line_q, line_d;
  logic [NWAYS_W-1:0]         way_q, way_d;

  logic [NWAYS_W-1:0]         inv_idx;
  logic                       inv_found;

  // The one-hot policy choice carries the same information as the binary
  // form; only the binary form is needed to latch the victim.
  logic                       unused_rep_sel;
  assign unused_rep_sel = ^rep_sel_i;

  iob_cache_prio_enc #(
    .N (N_WAYS),
    .W (NWAYS_W)
  ) u_prio_enc (
    .in_i    (~valid_bits_i),
    .idx_o   (inv_idx),
    .found_o (inv_found)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      line_q  <= '0;
      way_q   <= '0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      way_q   <= way_d;
    end
  end

  // Terminal word is detected on an all-ones counter, so no request is ever
  // issued for a wrapped word offset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    line_d  = line_q;
    way_d   = way_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_valid_i) begin
          tag_d   = miss_tag_i;
          line_d  = miss_line_i;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        way_d   = inv_found ? inv_idx : rep_sel_bin_i;
        cnt_d   = '0;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (be_ack_i) begin
          cnt_d = cnt_q + WORD_OFFSET_W'(1);
          if (cnt_q == {WORD_OFFSET_W{1'b1}}) begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // In IDLE the valid/policy memories are pointed at the incoming miss so
  // their combinational read is ready when SELECT needs it.
  always_comb begin
    miss_ready_o = (state_q == ST_IDLE);
    rep_line_o   = (state_q == ST_IDLE) ? miss_line_i : line_q;
    be_req_o     = (state_q == ST_FILL);
    be_addr_o    = {tag_q, line_q, cnt_q};
    data_we_o    = be_req_o & be_ack_i;
    data_way_o   = way_q;
    data_word_o  = cnt_q;
    data_wdata_o = be_rdata_i;
    tag_we_o     = (state_q == ST_COMMIT);
    tag_o        = tag_q;
    rep_we_o     = (state_q == ST_COMMIT);
    done_o       = (state_q == ST_COMMIT);
    rep_hit_o    = (state_q == ST_COMMIT) ? (N_WAYS'(1) << way_q) : '0;
  end

endmodule

// File: tb/tb_iob_cache_line_refill.sv
// Self-checking bench for iob_cache_line_refill: table-driven refills plus
// hand-written reset, stall, clock-enable and PLRU sequences.
module tb_iob_cache_line_refill;

  logic        clk;
  logic        arst_n;
  logic        cke;
  logic        miss_valid;
  logic        miss_ready;
  logic [6:0]  miss_line;
  logic [19:0] miss_tag;
  logic [7:0]  valid_bits;
  logic [7:0]  rep_sel;
  logic [2:0]  rep_sel_bin;
  logic [6:0]  rep_line;
  logic        rep_we;
  logic [7:0]  rep_hit;
  logic        be_req;
  logic [29:0] be_addr;
  logic        be_ack;
  logic [31:0] be_rdata;
  logic        data_we;
  logic [2:0]  data_way;
  logic [2:0]  data_word;
  logic [31:0] data_wdata;
  logic        tag_we;
  logic [19:0] tag_out;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]  vb;
    logic [2:0]  sel_bin;
    logic [7:0]  sel_oh;
    logic [6:0]  line;
    logic [19:0] tag;
    logic [2:0]  exp_victim;
  } vec_t;

  typedef struct {
    logic [2:0]  way;
    logic [2:0]  word;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[6];
  wr_t  sb_q[$];
  logic [6:0] plru;

  iob_cache_line_refill dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .cke_i         (cke),
    .miss_valid_i  (miss_valid),
    .miss_ready_o  (miss_ready),
    .miss_line_i   (miss_line),
    .miss_tag_i    (miss_tag),
    .valid_bits_i  (valid_bits),
    .rep_sel_i     (rep_sel),
    .rep_sel_bin_i (rep_sel_bin),
    .rep_line_o    (rep_line),
    .rep_we_o      (rep_we),
    .rep_hit_o     (rep_hit),
    .be_req_o      (be_req),
    .be_addr_o     (be_addr),
    .be_ack_i      (be_ack),
    .be_rdata_i    (be_rdata),
    .data_we_o     (data_we),
    .data_way_o    (data_way),
    .data_word_o   (data_word),
    .data_wdata_o  (data_wdata),
    .tag_we_o      (tag_we),
    .tag_o         (tag_out),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Back-end memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] be_data(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_C3C3;
  endfunction

  // Tree PLRU: bit 0 at a node means the left subtree is the victim side.
  function automatic logic [2:0] plru_victim(input logic [6:0] t);
    int n = 0;
    for (int l = 0; l < 3; l++) n = 2 * n + 1 + int'(t[n]);
    return 3'(n - 7);
  endfunction

  task automatic plru_touch(input logic [7:0] hit);
    int w = -1;
    int n = 0;
    logic [2:0] wb;
    for (int i = 7; i >= 0; i--) if (hit[i]) w = i;
    if (w >= 0) begin
      wb = 3'(w);
      for (int l = 2; l >= 0; l--) begin
        plru[n] = ~wb[l];
        n = 2 * n + 1 + int'(wb[l]);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete refill. Optional back-end stall and clock-enable freeze
  // are inserted before the given word; hold_en keeps a second miss pending.
  task automatic applyStimulus(input logic [7:0] vb, input logic [2:0] sel_bin,
                               input logic [7:0] sel_oh, input logic [6:0] line,
                               input logic [19:0] tag, input logic [2:0] exp_victim,
                               input int stall_word, input int stall_len,
                               input int freeze_word, input int freeze_len,
                               input logic hold_en, input logic [19:0] hold_tag);
    logic [29:0] addr;
    wr_t e;
    @(negedge clk);
    cke = 1'b1; miss_valid = 1'b1; miss_line = line; miss_tag = tag;
    valid_bits = vb; rep_sel_bin = sel_bin; rep_sel = sel_oh; be_ack = 1'b0;
    #1;
    checkOutput("accept_ready", miss_ready, 1);
    checkOutput("idle_rep_line", rep_line, line);
    @(negedge clk);
    miss_valid = hold_en;
    miss_tag = hold_tag;
    #1;
    checkOutput("select_ready", miss_ready, 0);
    checkOutput("select_rep_line", rep_line, line);
    checkOutput("select_no_req", be_req, 0);
    checkOutput("select_no_done", done, 0);
    for (int w = 0; w < 8; w++) begin
      addr = {tag, line, 3'(w)};
      if (w == freeze_word) begin
        for (int k = 0; k < freeze_len; k++) begin
          @(negedge clk);
          cke = 1'b0; be_ack = 1'b0;
          #1;
          checkOutput("freeze_addr", be_addr, addr);
          checkOutput("freeze_ready", miss_ready, 0);
        end
      end
      if (w == stall_word) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          cke = 1'b1; be_ack = 1'b0;
          #1;
          checkOutput("stall_addr", be_addr, addr);
          checkOutput("stall_no_we", data_we, 0);
        end
      end
      @(negedge clk);
      cke = 1'b1; be_ack = 1'b1; be_rdata = be_data(addr);
      sb_q.push_back('{way: exp_victim, word: 3'(w), data: be_data(addr)});
      #1;
      checkOutput("fill_req", be_req, 1);
      checkOutput("fill_addr", be_addr, addr);
      if (data_we && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("data_way", data_way, e.way);
        checkOutput("data_word", data_word, e.word);
        checkOutput("data_wdata", data_wdata, e.data);
      end else begin
        checkOutput("data_we", data_we, 1);
        sb_q.delete();
      end
    end
    @(negedge clk);
    be_ack = 1'b0;
    #1;
    checkOutput("commit_done", done, 1);
    checkOutput("commit_tag_we", tag_we, 1);
    checkOutput("commit_tag", tag_out, tag);
    checkOutput("commit_rep_we", rep_we, 1);
    checkOutput("commit_rep_hit", rep_hit, 8'(1) << exp_victim);
    checkOutput("commit_no_req", be_req, 0);
    if (rep_we && rep_line == 7'h12) plru_touch(rep_hit);
    if (!hold_en) begin
      @(negedge clk);
      #1;
      checkOutput("post_done", done, 0);
      checkOutput("post_ready", miss_ready, 1);
      checkOutput("post_rep_hit", rep_hit, 0);
    end
  endtask

  initial begin
    logic [2:0] plru_exp[8];
    logic [2:0] v;
    logic [29:0] addr;
    plru_exp = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    vecs[0] = '{vb: 8'h00,        sel_bin: 3'd5, sel_oh: 8'h20, line: 7'h05, tag: 20'h12345, exp_victim: 3'd0};
    vecs[1] = '{vb: 8'b1110_1111, sel_bin: 3'd2, sel_oh: 8'h01, line: 7'h33, tag: 20'hABCDE, exp_victim: 3'd4};
    vecs[2] = '{vb: 8'hFF,        sel_bin: 3'd3, sel_oh: 8'h08, line: 7'h7F, tag: 20'hFFFFF, exp_victim: 3'd3};
    vecs[3] = '{vb: 8'h7F,        sel_bin: 3'd1, sel_oh: 8'h02, line: 7'h00, tag: 20'h00001, exp_victim: 3'd7};
    vecs[4] = '{vb: 8'hFD,        sel_bin: 3'd0, sel_oh: 8'h01, line: 7'h41, tag: 20'h5A5A5, exp_victim: 3'd1};
    vecs[5] = '{vb: 8'h3F,        sel_bin: 3'd0, sel_oh: 8'h01, line: 7'h2A, tag: 20'hC0FFE, exp_victim: 3'd6};

    arst_n = 1'b0; cke = 1'b1; miss_valid = 1'b0; miss_line = '0; miss_tag = '0;
    valid_bits = '0; rep_sel = '0; rep_sel_bin = '0; be_ack = 1'b0; be_rdata = '0;
    plru = '0;

    // Reset held: ready high, every strobe low.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ready", miss_ready, 1);
    checkOutput("rst_be_req", be_req, 0);
    checkOutput("rst_data_we", data_we, 0);
    checkOutput("rst_tag_we", tag_we, 0);
    checkOutput("rst_rep_we", rep_we, 0);
    checkOutput("rst_rep_hit", rep_hit, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Reset asserted mid-FILL at word 3: back to IDLE, no tag commit.
    @(negedge clk);
    miss_valid = 1'b1; miss_line = 7'h12; miss_tag = 20'hABCDE; valid_bits = 8'h00;
    @(negedge clk);
    miss_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      addr = {20'hABCDE, 7'h12, 3'(w)};
      be_ack = 1'b1; be_rdata = be_data(addr);
    end
    @(negedge clk);
    be_ack = 1'b0;
    #1;
    checkOutput("abort_addr", be_addr, {20'hABCDE, 7'h12, 3'd3});
    arst_n = 1'b0;
    #1;
    checkOutput("abort_ready", miss_ready, 1);
    checkOutput("abort_req", be_req, 0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_no_tag_we", tag_we, 0);
      checkOutput("abort_idle", miss_ready, 1);
    end

    // Table-driven refills, zero-wait back-end.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].vb, vecs[i].sel_bin, vecs[i].sel_oh, vecs[i].line,
                    vecs[i].tag, vecs[i].exp_victim, -1, 0, -1, 0, 1'b0, 20'h0);
    end

    // Full line 0x12 with a tree PLRU policy beside the block.
    plru = '0;
    for (int i = 0; i < 8; i++) begin
      v = plru_victim(plru);
      applyStimulus(8'hFF, v, 8'(1) << v, 7'h12, 20'h10000 + 20'(i),
                    plru_exp[i], -1, 0, -1, 0, 1'b0, 20'h0);
    end

    // Back-end stalls 5 cycles on word 2.
    applyStimulus(8'hFF, 3'd2, 8'h04, 7'h12, 20'h2BEEF, 3'd2, 2, 5, -1, 0, 1'b0, 20'h0);

    // Clock enable low 3 cycles during FILL with a second miss pending;
    // the pending miss must be taken the cycle after done_o.
    applyStimulus(8'h00, 3'd0, 8'h01, 7'h12, 20'h31337, 3'd0, -1, 0, 1, 3, 1'b1, 20'h77777);
    applyStimulus(8'h00, 3'd0, 8'h01, 7'h12, 20'h77777, 3'd0, -1, 0, -1, 0, 1'b0, 20'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
